// File: rtl/d8m_camera_tx_emulator_pkg.sv
// Shared types and constants for the D8M camera bus emulator: FSM states,
// pattern selector codes and the colour-bar table.
package d8m_cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FSTART,
        ST_LINE,
        ST_HBLANK,
        ST_FEND,
        ST_VBLANK
    } cam_state_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_BARS  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // {R,G,B} per bar, left to right: W, Y, C, G, M, R, B, K
    localparam logic [0:7][2:0] BAR_TABLE = {
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage

// File: rtl/d8m_camera_tx_emulator_if.sv
// D8M parallel camera bus: 12-bit pixel data with frame/line valid qualifiers.
interface d8m_camera_tx_emulator_if;

    logic [11:0] camera_d;
    logic        camera_fval;
    logic        camera_lval;

    modport master (output camera_d, output camera_fval, output camera_lval);
    modport slave  (input  camera_d, input  camera_fval, input  camera_lval);

endinterface

// File: rtl/d8m_camera_tx_emulator_pattern_gen.sv
// Combinational test-pattern source: maps pixel position, bar index and the
// latched pattern selector onto a raw RGGB Bayer sample.
module cam_pattern_gen
    import d8m_cam_pkg::*;
(
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic [2:0]  bar_idx,
    input  logic [1:0]  pat_sel,
    output logic [11:0] pixel
);

    logic [2:0] rgb;
    logic       chan;

    // Bayer site picks which colour channel of the bar is visible here
    always_comb begin
        rgb  = BAR_TABLE[bar_idx];
        chan = rgb[1];
        case ({y[0], x[0]})
            2'b00:   chan = rgb[2];
            2'b11:   chan = rgb[0];
            default: chan = rgb[1];
        endcase

        pixel = '0;
        case (pat_sel)
            PAT_HRAMP: pixel = x;
            PAT_VRAMP: pixel = y;
            PAT_BARS:  pixel = {12{chan}};
            PAT_CHECK: pixel = (x[0] ^ y[0]) ? 12'hFFF : 12'h000;
            default:   pixel = '0;
        endcase
    end

endmodule

// File: rtl/d8m_camera_tx_emulator.sv
// D8M camera sensor emulator: frame timing FSM, pixel counters and registered bus.
// Optional macro D8M_CAM_TX_FRAME_TAG_EN stamps frame_count into line 0, pixels 0 and 1.
module d8m_camera_tx_emulator
    import d8m_cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned FV_TO_LV = 8,
    parameter int unsigned LV_TO_FV = 8,
    parameter int unsigned V_BLANK  = 64
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             continuous,
    input  logic [1:0]                       pattern_sel,
    d8m_camera_tx_emulator_if.master         cam,
    output logic                             busy,
    output logic                             frame_done,
    output logic [15:0]                      frame_count
);

    localparam int unsigned XB = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YB = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned XW = (XB > 12) ? XB : 12;
    localparam int unsigned YW = (YB > 12) ? YB : 12;

    localparam int unsigned CM1  = (FV_TO_LV > H_BLANK) ? FV_TO_LV : H_BLANK;
    localparam int unsigned CM2  = (LV_TO_FV > V_BLANK) ? LV_TO_FV : V_BLANK;
    localparam int unsigned CMAX = (CM1 > CM2) ? CM1 : CM2;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] FS_LAST  = CW'(FV_TO_LV - 1);
    localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] FE_LAST  = CW'(LV_TO_FV - 1);
    localparam logic [CW-1:0] VB_LAST  = CW'(V_BLANK - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);

    cam_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic [2:0]    bar, bar_nxt;
    logic [SW-1:0] sub, sub_nxt;
    logic [1:0]    pat_q;
    logic          cont_q;
    logic [11:0]   pix_pat, pix_out;
    logic [11:0]   d_q;
    logic          fval_q, lval_q;

    // Next-state and counter decisions; x/y/bar describe the pixel shown next cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x_nxt     = x;
        y_nxt     = y;
        bar_nxt   = bar;
        sub_nxt   = sub;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FSTART;
                    cnt_nxt   = '0;
                end
            end
            ST_FSTART: begin
                x_nxt   = '0;
                y_nxt   = '0;
                bar_nxt = '0;
                sub_nxt = '0;
                if (cnt == FS_LAST) begin
                    state_nxt = ST_LINE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_LINE: begin
                if (x == X_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (y == Y_LAST) ? ST_FEND : ST_HBLANK;
                end else begin
                    x_nxt = x + XW'(1);
                    if (sub == SUB_LAST) begin
                        sub_nxt = '0;
                        if (bar != 3'd7)
                            bar_nxt = bar + 3'd1;
                    end else begin
                        sub_nxt = sub + SW'(1);
                    end
                end
            end
            ST_HBLANK: begin
                if (cnt == HB_LAST) begin
                    state_nxt = ST_LINE;
                    cnt_nxt   = '0;
                    x_nxt     = '0;
                    y_nxt     = y + YW'(1);
                    bar_nxt   = '0;
                    sub_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_FEND: begin
                if (cnt == FE_LAST) begin
                    state_nxt = ST_VBLANK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_VBLANK: begin
                if (cnt == VB_LAST) begin
                    state_nxt = cont_q ? ST_FSTART : ST_IDLE;
                    cnt_nxt   = '0;
                    x_nxt     = '0;
                    y_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    cam_pattern_gen u_pattern (
        .x       (x_nxt[11:0]),
        .y       (y_nxt[11:0]),
        .bar_idx (bar_nxt),
        .pat_sel (pat_q),
        .pixel   (pix_pat)
    );

    // Frame tag overrides the first two pixels of line 0 with the completed-frame count
    always_comb begin
        pix_out = pix_pat;
`ifdef D8M_CAM_TX_FRAME_TAG_EN
        if (y_nxt == '0 && x_nxt == '0)
            pix_out = frame_count[11:0];
        else if (y_nxt == '0 && x_nxt == XW'(1))
            pix_out = {8'h0, frame_count[15:12]};
`endif
    end

    // Timing FSM with every bus and status output registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            x           <= '0;
            y           <= '0;
            bar         <= '0;
            sub         <= '0;
            pat_q       <= PAT_HRAMP;
            cont_q      <= 1'b0;
            d_q         <= '0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            x      <= x_nxt;
            y      <= y_nxt;
            bar    <= bar_nxt;
            sub    <= sub_nxt;
            cont_q <= continuous;
            if (state_nxt == ST_FSTART && state != ST_FSTART)
                pat_q <= pattern_sel;
            fval_q     <= state_nxt inside {ST_FSTART, ST_LINE, ST_HBLANK, ST_FEND};
            lval_q     <= (state_nxt == ST_LINE);
            d_q        <= (state_nxt == ST_LINE) ? pix_out : 12'h000;
            busy       <= (state_nxt != ST_IDLE);
            frame_done <= (state == ST_FEND) && (state_nxt == ST_VBLANK);
            if (state == ST_FEND && state_nxt == ST_VBLANK)
                frame_count <= frame_count + 16'd1;
        end
    end

    assign cam.camera_d    = d_q;
    assign cam.camera_fval = fval_q;
    assign cam.camera_lval = lval_q;

endmodule

// File: tb/tb_d8m_camera_tx_emulator.sv
// Directed bench for the D8M camera emulator with a small 16x4 frame geometry.
module tb_d8m_camera_tx_emulator;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        continuous;
    logic [1:0]  pattern_sel;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    d8m_camera_tx_emulator_if cam ();

    d8m_camera_tx_emulator #(
        .H_ACTIVE (16),
        .H_BLANK  (4),
        .V_ACTIVE (4),
        .FV_TO_LV (3),
        .LV_TO_FV (2),
        .V_BLANK  (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .continuous  (continuous),
        .pattern_sel (pattern_sel),
        .cam         (cam),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived bar rows: even lines alternate R/G sites, odd lines G/B sites
    localparam logic [11:0] BARS_EVEN [16] = '{
        12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF,
        12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000
    };
    localparam logic [11:0] BARS_ODD [16] = '{
        12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000,
        12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000
    };

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    int fv_len, lv_cnt, lv_len_err, gap_cnt, gap_err, dz_err;
    int lv_first, lv_last_end, done_in_frame, done_at_fall, vb_len, pix_err;
    int pat_exp, frame_fc;
    int poke_en = 0;
    int chg_pat_at = -1;
    int clr_cont_at = -1;

    task automatic checkOutput(input string tag, input int got, input int expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [11:0] expPix(input int pat, input int x, input int y, input int fc);
        logic [11:0] v;
        logic        tag_en;
        case (pat)
            0:       v = 12'(x);
            1:       v = 12'(y);
            2:       v = (y % 2 == 0) ? BARS_EVEN[x] : BARS_ODD[x];
            default: v = (((x ^ y) & 1) != 0) ? 12'hFFF : 12'h000;
        endcase
`ifdef D8M_CAM_TX_FRAME_TAG_EN
        tag_en = 1'b1;
`else
        tag_en = 1'b0;
`endif
        if (tag_en && y == 0 && x < 2)
            v = (x == 0) ? 12'(fc) : 12'((fc >> 12) & 15);
        return v;
    endfunction

    task automatic applyStimulus(input logic [1:0] pat, input logic cont);
        @(negedge clk);
        checkOutput("idle_before_start", int'(cam.camera_fval), 0);
        pattern_sel = pat;
        continuous  = cont;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("fval_next_cycle", int'(cam.camera_fval), 1);
    endtask

    // Walks one frame and its vertical blanking at negedges, collecting timing and pixel errors
    task automatic captureFrame();
        int  wait_n, xi, yi, gap_run;
        logic prev_lv;
        fv_len = 0; lv_cnt = 0; lv_len_err = 0; gap_cnt = 0; gap_err = 0; dz_err = 0;
        lv_first = -1; lv_last_end = 0; done_in_frame = 0; done_at_fall = 0;
        vb_len = 0; pix_err = 0;
        wait_n = 0;
        while (cam.camera_fval !== 1'b1 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        if (cam.camera_fval !== 1'b1) begin
            checkOutput("fval_rise_timeout", 0, 1);
            return;
        end
        prev_lv = 1'b0; xi = 0; yi = 0; gap_run = 0;
        while (cam.camera_fval === 1'b1 && fv_len < 400) begin
            if (cam.camera_lval === 1'b1) begin
                if (!prev_lv) begin
                    if (lv_first < 0) lv_first = fv_len;
                    if (yi > 0) begin
                        gap_cnt++;
                        if (gap_run != 4) gap_err++;
                    end
                    xi = 0;
                end
                if (yi < 4 && xi < 16 && cam.camera_d !== expPix(pat_exp, xi, yi, frame_fc))
                    pix_err++;
                xi++;
                lv_last_end = fv_len + 1;
            end else begin
                if (cam.camera_d !== 12'h000) dz_err++;
                if (prev_lv) begin
                    lv_cnt++;
                    if (xi != 16) lv_len_err++;
                    yi++;
                    gap_run = 0;
                end
                gap_run++;
            end
            if (frame_done === 1'b1) done_in_frame++;
            start = (poke_en != 0) && (fv_len == 20 || fv_len == 50);
            if (fv_len == chg_pat_at) pattern_sel = 2'd0;
            if (fv_len == clr_cont_at) continuous = 1'b0;
            prev_lv = cam.camera_lval;
            fv_len++;
            @(negedge clk);
        end
        start = 1'b0;
        done_at_fall = int'(frame_done);
        while (cam.camera_fval !== 1'b1 && busy === 1'b1 && vb_len < 100) begin
            if (frame_done === 1'b1) done_in_frame++;
            start = (poke_en != 0) && (vb_len == 2);
            vb_len++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic verifyFrame(input string name);
        checkOutput({name, "_fv_len"}, fv_len, 81);
        checkOutput({name, "_lv_pulses"}, lv_cnt, 4);
        checkOutput({name, "_lv_len_err"}, lv_len_err, 0);
        checkOutput({name, "_gaps"}, gap_cnt, 3);
        checkOutput({name, "_gap_err"}, gap_err, 0);
        checkOutput({name, "_d_zero_err"}, dz_err, 0);
        checkOutput({name, "_fv_to_lv"}, lv_first, 3);
        checkOutput({name, "_lv_to_fv"}, fv_len - lv_last_end, 2);
        checkOutput({name, "_done_at_fall"}, done_at_fall, 1);
        checkOutput({name, "_done_pulses"}, done_in_frame, 1);
        checkOutput({name, "_pix_err"}, pix_err, 0);
        checkOutput({name, "_vblank"}, vb_len, 5);
        checkOutput({name, "_frame_count"}, int'(frame_count), exp_count);
    endtask

    task automatic checkIdle(input string name, input int cycles);
        int act = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (cam.camera_fval !== 1'b0 || busy !== 1'b0 || cam.camera_lval !== 1'b0) act++;
        end
        checkOutput(name, act, 0);
    endtask

    task automatic runSingle(input string name, input logic [1:0] pat, input int expect_pat);
        applyStimulus(pat, 1'b0);
        pat_exp  = expect_pat;
        frame_fc = exp_count;
        captureFrame();
        exp_count++;
        verifyFrame(name);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wait_n;
        reset_n = 1'b0; start = 1'b0; continuous = 1'b0; pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_fval", int'(cam.camera_fval), 0);
        checkOutput("rst_lval", int'(cam.camera_lval), 0);
        checkOutput("rst_d", int'(cam.camera_d), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(frame_done), 0);
        checkOutput("rst_count", int'(frame_count), 0);
        reset_n = 1'b1;
        checkIdle("idle_after_reset", 9);

        $display("[TB] single frame, h-ramp");
        runSingle("s1", 2'd0, 0);
        checkIdle("s1_stays_idle", 10);

        $display("[TB] start pulses while busy");
        poke_en = 1;
        runSingle("s5", 2'd0, 0);
        poke_en = 0;
        checkIdle("s5_stays_idle", 10);

        $display("[TB] patterns");
        runSingle("vramp", 2'd1, 1);
        runSingle("bars", 2'd2, 2);
        chg_pat_at = 30;
        runSingle("chk_hold", 2'd3, 3);
        chg_pat_at = -1;
        checkOutput("pat_sel_changed", int'(pattern_sel), 0);
        runSingle("after_chg", pattern_sel, 0);

        $display("[TB] continuous frames");
        applyStimulus(2'd1, 1'b1);
        pat_exp = 1;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) clr_cont_at = 40;
            frame_fc = exp_count;
            captureFrame();
            exp_count++;
            verifyFrame($sformatf("cont%0d", f));
        end
        clr_cont_at = -1;
        checkOutput("cont_busy_end", int'(busy), 0);
        checkIdle("cont_stays_idle", 10);

        $display("[TB] asynchronous reset mid-line");
        applyStimulus(2'd0, 1'b0);
        wait_n = 0;
        while (cam.camera_lval !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_lval", int'(cam.camera_lval), 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_fval", int'(cam.camera_fval), 0);
        checkOutput("async_rst_lval", int'(cam.camera_lval), 0);
        checkOutput("async_rst_d", int'(cam.camera_d), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_count", int'(frame_count), 0);
        exp_count = 0;
        @(negedge clk);
        reset_n = 1'b1;
        checkIdle("post_reset_idle", 20);
        runSingle("post_reset", 2'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
